mem_line_reader: RTL
====================

Name: mem_line_reader

Overview:
- Reads back a 5x5 bit-cell memory one cell per cycle over the memory's index/read port, in row-major order (index = 5*row + col).
- Assembles the cells into a 25-bit line and hands that line to a consumer over a valid/ready handshake.
- It is the read-out counterpart of the path that loads a 25-bit line into the memory and updates cells through the datapath.
- It sits between the memory block and the downstream controller or test harness.

Parameters:
- SIZE, 5: width of the memory index bus; also the row and column count (5x5 grid).
- MEMSIZE, 25: number of cells and width of the assembled line; must equal 25 for SIZE=5.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a read-out sweep; sampled only in IDLE.
- en  input  1  sweep enable; when low during READ, the sweep stalls.
- index  output  SIZE  memory cell index = 5*row + col, range 0..24.
- read  output  1  memory read strobe.
- rdata  input  1  memory cell data; combinational response to index/read, sampled on the same edge.
- line  output  MEMSIZE  assembled line; bit k holds cell k.
- line_valid  output  1  line is complete and stable.
- line_ready  input  1  consumer accepts the line.
- busy  output  1  high in READ and HOLD.
- done  output  1  one-cycle pulse on handshake completion.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; row=col=0; line=0; index=0; read=0; line_valid=0; busy=0; done=0.
- Row and column are 3-bit counters. index = row + (row<<2) + col, zero-extended to SIZE; no overflow is possible within 0..24.
- IDLE:
  - read=0, line_valid=0, busy=0.
  - start=1 -> READ; row and col cleared; line cleared to 0.
- READ:
  - busy=1.
  - read = en, so read is low on stalled cycles.
  - On each edge with en=1: line[index] <= rdata; col increments.
  - When col=4: col <= 0 and row increments.
  - When row=4 and col=4 (index 24), the capture happens and the state goes to HOLD.
  - With en=1 on every cycle, exactly 25 read cycles occur from READ entry to HOLD entry.
  - With en=0: no capture, counters frozen, index held at its current value.
- HOLD:
  - line_valid=1, busy=1, read=0; line stays stable until accepted.
  - line_ready=1 -> IDLE, with done=1 for exactly the next cycle.
  - line is retained in IDLE until the next start.
- line_ready is ignored outside HOLD. start is ignored outside IDLE, including start in the same cycle as the HOLD->IDLE transition.
- If start and line_ready arrive in the cycle right after HOLD->IDLE, the new sweep starts normally; done and the new busy may overlap by one cycle.
- Reset asserted mid-sweep or during HOLD aborts immediately: partial line discarded (line=0) and no done pulse.
- Outputs index, read, line_valid and busy decode from state and counters only; no combinational path from line_ready or start.

Optional Feature:
- Macro: MEM_LINE_READER_PARITY_EN.
- When defined:
  - Extra output port parity (1 bit): running XOR of every captured rdata bit.
  - Cleared on reset and on start.
  - Equals ^line whenever line_valid=1.
  - Held with line in IDLE.
- When not defined: the port does not exist and no parity logic is built; all other behaviour is identical.

Test Plan:
- Memory preloaded with 25'h1FFFFFF; pulse start; en=1; line_ready=1 held -> index sequence 0,1,...,24 on consecutive cycles; line_valid rises the cycle after index 24; line=25'h1FFFFFF; done high for exactly 1 cycle; 27 cycles from start to done.
- Memory = 25'h0A5A5A5 (cell k = bit k); line_ready held 0 for 10 cycles in HOLD -> line_valid stays 1, line=25'h0A5A5A5 stable, read=0; line_ready=1 -> IDLE and done pulse.
- en low for 3 cycles while index=7 -> read=0 and index stays 7 during the stall; resumes at 7; final line equals memory contents; read strobe counted exactly 25 times.
- rst pulsed low mid-sweep at index 12 -> all outputs reset asynchronously (before the next edge); new start gives a full correct sweep from index 0.
- start pulsed during READ and during HOLD -> ignored; index sequence unaffected; single done pulse.
- With MEM_LINE_READER_PARITY_EN defined, memory = 25'h0000007 -> parity=1 at line_valid; memory = 25'h0000003 -> parity=0.

Source files
------------

// File: rtl/mem_line_reader.sv
// Sweeps a 5x5 bit-cell memory in row-major order and hands the assembled 25-bit line to a consumer over valid/ready.
// Optional build macro MEM_LINE_READER_PARITY_EN adds a running-XOR parity output over the captured cells.
module mem_line_reader #(
    parameter int SIZE    = 5,
    parameter int MEMSIZE = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               en,
    output logic [SIZE-1:0]    index,
    output logic               read,
    input  logic               rdata,
    output logic [MEMSIZE-1:0] line,
    output logic               line_valid,
    input  logic               line_ready,
    output logic               busy,
    output logic               done
`ifdef MEM_LINE_READER_PARITY_EN
    ,
    output logic               parity
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           row_q, row_d;
    logic [2:0]           col_q, col_d;
    logic [MEMSIZE-1:0]   line_q, line_d;
    logic                 done_q, done_d;
    logic [SIZE-1:0]      index_s;
    logic                 last_cell_s;
    logic                 capture_s;
    logic                 launch_s;

    assign index_s     = SIZE'(row_q) + SIZE'({row_q, 2'b00}) + SIZE'(col_q);
    assign last_cell_s = (row_q == 3'd4) && (col_q == 3'd4);
    assign capture_s   = (state_q == READ) && en;
    assign launch_s    = (state_q == IDLE) && start;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (en && last_cell_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = READ;
                end
            end
            HOLD: begin
                if (line_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from state and counters; read follows en only while sweeping.
    always_comb begin
        index      = index_s;
        read       = 1'b0;
        line_valid = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                read       = 1'b0;
                line_valid = 1'b0;
                busy       = 1'b0;
            end
            READ: begin
                read       = en;
                line_valid = 1'b0;
                busy       = 1'b1;
            end
            HOLD: begin
                read       = 1'b0;
                line_valid = 1'b1;
                busy       = 1'b1;
            end
            default: begin
                read       = 1'b0;
                line_valid = 1'b0;
                busy       = 1'b0;
            end
        endcase
    end

    // Counter and line capture; counters wrap to 0 after the last cell so index never leaves 0..24.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        line_d = line_q;
        done_d = (state_q == HOLD) && line_ready;
        if (launch_s) begin
            row_d  = 3'd0;
            col_d  = 3'd0;
            line_d = {MEMSIZE{1'b0}};
        end else if (capture_s) begin
            line_d[index_s] = rdata;
            if (last_cell_s) begin
                row_d = 3'd0;
                col_d = 3'd0;
            end else if (col_q == 3'd4) begin
                row_d = row_q + 3'd1;
                col_d = 3'd0;
            end else begin
                row_d = row_q;
                col_d = col_q + 3'd1;
            end
        end else begin
            row_d  = row_q;
            col_d  = col_q;
            line_d = line_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q  <= 3'd0;
            col_q  <= 3'd0;
            line_q <= {MEMSIZE{1'b0}};
            done_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            line_q <= line_d;
            done_q <= done_d;
        end
    end

    assign line = line_q;
    assign done = done_q;

`ifdef MEM_LINE_READER_PARITY_EN
    logic parity_q, parity_d;

    // Running parity of captured cells, restarted with each sweep.
    always_comb begin
        parity_d = parity_q;
        if (launch_s) begin
            parity_d = 1'b0;
        end else if (capture_s) begin
            parity_d = parity_q ^ rdata;
        end else begin
            parity_d = parity_q;
        end
    end

    // Parity register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

endmodule
